// File: rtl/pito_program_loader.sv
// Loads imem/dmem of the pito rv32 core from a word stream while holding the core in reset,
// then releases it. Optional checksum verification is enabled with PITO_LOADER_CHECKSUM_EN.
module pito_program_loader #(
    parameter int                DATA_W          = 32,
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] IMEM_BASE       = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] DMEM_BASE       = 32'h0000_2000,
    parameter int                IMEM_WORDS      = 4096,
    parameter int                DMEM_WORDS      = 4096,
    parameter int                RST_HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       imem_len,
    input  logic [15:0]       dmem_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              pito_io_rst_n,
    output logic              pito_io_program,
    output logic              pito_io_imem_w_en,
    output logic [ADDR_W-1:0] pito_io_imem_addr,
    output logic [DATA_W-1:0] pito_io_imem_data,
    output logic              pito_io_dmem_w_en,
    output logic [ADDR_W-1:0] pito_io_dmem_addr,
    output logic [DATA_W-1:0] pito_io_dmem_data,
`ifdef PITO_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] exp_csum,
    output logic              err_csum,
`endif
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (RST_HOLD_CYCLES > 1) ? HOLD_W'(RST_HOLD_CYCLES - 1) : '0;

    typedef enum logic [2:0] {IDLE, HOLD, LD_IMEM, LD_DMEM, FLUSH, RUN} state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]       idx_q, idx_d;
    logic [15:0]       imem_len_q, imem_len_d;
    logic [15:0]       dmem_len_q, dmem_len_d;
    logic              err_len_q, err_len_d;
    logic              done_q, done_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_data_q, imem_data_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_data_q, dmem_data_d;
    logic              len_bad;
    logic              handshake;
`ifdef PITO_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_csum_q, err_csum_d;
`endif

    assign s_ready         = (state_q == LD_IMEM) || (state_q == LD_DMEM);
    assign handshake       = s_valid && s_ready;
    assign len_bad         = ({1'b0, imem_len} > 17'(IMEM_WORDS)) || ({1'b0, dmem_len} > 17'(DMEM_WORDS));
    assign pito_io_rst_n   = (state_q == RUN);
    assign pito_io_program = (state_q == HOLD) || s_ready;
    assign busy            = pito_io_program || (state_q == FLUSH);
    assign done            = done_q;
    assign err_len         = err_len_q;
    assign pito_io_imem_w_en = imem_we_q;
    assign pito_io_imem_addr = imem_addr_q;
    assign pito_io_imem_data = imem_data_q;
    assign pito_io_dmem_w_en = dmem_we_q;
    assign pito_io_dmem_addr = dmem_addr_q;
    assign pito_io_dmem_data = dmem_data_q;
`ifdef PITO_LOADER_CHECKSUM_EN
    assign err_csum = err_csum_q;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        imem_len_d  = imem_len_q;
        dmem_len_d  = dmem_len_q;
        err_len_d   = err_len_q;
        done_d      = 1'b0;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        dmem_we_d   = 1'b0;
        dmem_addr_d = dmem_addr_q;
        dmem_data_d = dmem_data_q;
`ifdef PITO_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        exp_d      = exp_q;
        err_csum_d = err_csum_q;
        if (handshake) csum_d = csum_q + s_data;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    if (len_bad) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        err_len_d  = 1'b0;
                        imem_len_d = imem_len;
                        dmem_len_d = dmem_len;
                        hold_d     = '0;
                        idx_d      = '0;
                        state_d    = HOLD;
`ifdef PITO_LOADER_CHECKSUM_EN
                        csum_d     = '0;
                        exp_d      = exp_csum;
                        err_csum_d = 1'b0;
`endif
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (imem_len_q != 16'd0)      state_d = LD_IMEM;
                    else if (dmem_len_q != 16'd0) state_d = LD_DMEM;
                    else                          state_d = FLUSH;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            LD_IMEM: begin
                if (handshake) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = IMEM_BASE + (ADDR_W'(idx_q) << 2);
                    imem_data_d = s_data;
                    idx_d       = idx_q + 16'd1;
                    if (idx_q + 16'd1 == imem_len_q) begin
                        idx_d   = '0;
                        state_d = (dmem_len_q != 16'd0) ? LD_DMEM : FLUSH;
                    end
                end
            end
            LD_DMEM: begin
                if (handshake) begin
                    dmem_we_d   = 1'b1;
                    dmem_addr_d = DMEM_BASE + (ADDR_W'(idx_q) << 2);
                    dmem_data_d = s_data;
                    idx_d       = idx_q + 16'd1;
                    if (idx_q + 16'd1 == dmem_len_q) begin
                        idx_d   = '0;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
`ifdef PITO_LOADER_CHECKSUM_EN
                if (csum_q != exp_q) begin
                    err_csum_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
`else
                state_d = RUN;
                done_d  = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            idx_q       <= '0;
            imem_len_q  <= '0;
            dmem_len_q  <= '0;
            err_len_q   <= 1'b0;
            done_q      <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_data_q <= '0;
`ifdef PITO_LOADER_CHECKSUM_EN
            csum_q      <= '0;
            exp_q       <= '0;
            err_csum_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            imem_len_q  <= imem_len_d;
            dmem_len_q  <= dmem_len_d;
            err_len_q   <= err_len_d;
            done_q      <= done_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            dmem_we_q   <= dmem_we_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_data_q <= dmem_data_d;
`ifdef PITO_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            exp_q       <= exp_d;
            err_csum_q  <= err_csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_pito_program_loader.sv
// Self-checking bench for pito_program_loader: randomized stream loads compared against
// a list-of-writes reference model derived from region bases and word order.
module tb_pito_program_loader;

    localparam int          HOLD_CYCLES = 4;
    localparam logic [31:0] IMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE   = 32'h0000_2000;

    typedef struct packed {
        logic        isDmem;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] imem_len;
    logic [15:0] dmem_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        pito_io_rst_n;
    logic        pito_io_program;
    logic        pito_io_imem_w_en;
    logic [31:0] pito_io_imem_addr;
    logic [31:0] pito_io_imem_data;
    logic        pito_io_dmem_w_en;
    logic [31:0] pito_io_dmem_addr;
    logic [31:0] pito_io_dmem_data;
    logic        busy;
    logic        done;
    logic        err_len;
`ifdef PITO_LOADER_CHECKSUM_EN
    logic [31:0] exp_csum;
    logic        err_csum;
`endif

    int          passCount  = 0;
    int          checkCount = 0;
    int          doneCount  = 0;
    int          bothHigh   = 0;
    logic [31:0] words[$];
    wr_t         expQ[$];
    wr_t         obsQ[$];

    pito_program_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .imem_len          (imem_len),
        .dmem_len          (dmem_len),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_ready           (s_ready),
        .pito_io_rst_n     (pito_io_rst_n),
        .pito_io_program   (pito_io_program),
        .pito_io_imem_w_en (pito_io_imem_w_en),
        .pito_io_imem_addr (pito_io_imem_addr),
        .pito_io_imem_data (pito_io_imem_data),
        .pito_io_dmem_w_en (pito_io_dmem_w_en),
        .pito_io_dmem_addr (pito_io_dmem_addr),
        .pito_io_dmem_data (pito_io_dmem_data),
`ifdef PITO_LOADER_CHECKSUM_EN
        .exp_csum          (exp_csum),
        .err_csum          (err_csum),
`endif
        .busy              (busy),
        .done              (done),
        .err_len           (err_len)
    );

    always #5 clk = ~clk;

    // Passive observer of the core-facing write ports, sampled away from the active edge.
    always @(negedge clk) begin
        if (pito_io_imem_w_en) obsQ.push_back('{1'b0, pito_io_imem_addr, pito_io_imem_data});
        if (pito_io_dmem_w_en) obsQ.push_back('{1'b1, pito_io_dmem_addr, pito_io_dmem_data});
        if (pito_io_imem_w_en && pito_io_dmem_w_en) bothHigh++;
        if (done) doneCount++;
    end

    task automatic startLoad(input int nI, input int nD);
        @(negedge clk);
        imem_len = 16'(nI);
        dmem_len = 16'(nD);
`ifdef PITO_LOADER_CHECKSUM_EN
        exp_csum = '0;
        foreach (words[i]) exp_csum = exp_csum + words[i];
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives words[0..limit-1]; each call returns on the negedge after the last handshake.
    task automatic feedWords(input int limit, input int mode);
        int ptr = 0;
        int k = 0;
        logic v;
        while (ptr < limit && k < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = words[ptr];
            if (v && s_ready) ptr++;
            @(negedge clk);
            k++;
        end
        s_valid = 1'b0;
        s_data  = $urandom;
        checkCount++;
        if (ptr !== limit) $display("[TB] FAIL feed_timeout: accepted %0d required %0d", ptr, limit);
        else passCount++;
    endtask

    task automatic doLoad(input int nI, input int nD, input int mode, input bit directed);
        int d0;
        int holdLen;
        int k;
        words.delete();
        expQ.delete();
        for (int i = 0; i < nI + nD; i++) words.push_back(directed ? 32'hA0 + 32'(i) : $urandom);
        for (int i = 0; i < nI; i++) expQ.push_back('{1'b0, IMEM_BASE + 32'(4 * i), words[i]});
        for (int j = 0; j < nD; j++) expQ.push_back('{1'b1, DMEM_BASE + 32'(4 * j), words[nI + j]});
        d0 = doneCount;
        bothHigh = 0;
        startLoad(nI, nD);
        obsQ.delete();
        checkCount++;
        if ({pito_io_rst_n, pito_io_program, busy, err_len} !== 4'b0110)
            $display("[TB] FAIL load_entry: rst_n/program/busy/err_len=%b required 0110",
                     {pito_io_rst_n, pito_io_program, busy, err_len});
        else passCount++;
        holdLen = 0;
        while (pito_io_program && !s_ready && holdLen < 20) begin
            holdLen++;
            @(negedge clk);
        end
        checkCount++;
        if (holdLen !== HOLD_CYCLES) $display("[TB] FAIL hold_len: got %0d required %0d", holdLen, HOLD_CYCLES);
        else passCount++;
        feedWords(nI + nD, mode);
        k = 0;
        while (doneCount == d0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        checkCount++;
        if (doneCount - d0 !== 1) $display("[TB] FAIL done_pulses: got %0d required 1", doneCount - d0);
        else passCount++;
        checkCount++;
        if ({pito_io_rst_n, pito_io_program, busy, done, err_len} !== 5'b10000)
            $display("[TB] FAIL run_state: rst_n/program/busy/done/err_len=%b required 10000",
                     {pito_io_rst_n, pito_io_program, busy, done, err_len});
        else passCount++;
        checkCount++;
        if (bothHigh !== 0) $display("[TB] FAIL both_w_en: got %0d cycles required 0", bothHigh);
        else passCount++;
        checkCount++;
        if (obsQ.size() !== expQ.size()) $display("[TB] FAIL write_count: got %0d required %0d", obsQ.size(), expQ.size());
        else passCount++;
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkCount++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL write_%0d: got dmem=%0d addr=%h data=%h required dmem=%0d addr=%h data=%h", i,
                         obsQ[i].isDmem, obsQ[i].addr, obsQ[i].data, expQ[i].isDmem, expQ[i].addr, expQ[i].data);
            else passCount++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; imem_len = '0; dmem_len = '0;
`ifdef PITO_LOADER_CHECKSUM_EN
        exp_csum = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obsQ.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkCount++;
            if ({pito_io_rst_n, pito_io_program, s_ready, pito_io_imem_w_en, pito_io_dmem_w_en, busy, done, err_len} !== 8'b0)
                $display("[TB] FAIL idle_outputs: got %b required 00000000",
                         {pito_io_rst_n, pito_io_program, s_ready, pito_io_imem_w_en, pito_io_dmem_w_en, busy, done, err_len});
            else passCount++;
        end
        checkCount++;
        if ({pito_io_imem_addr, pito_io_dmem_addr, pito_io_imem_data, pito_io_dmem_data} !== 128'b0)
            $display("[TB] FAIL idle_addr_data: got nonzero required 0");
        else passCount++;
    endtask

    task automatic test_err_len();
        start = 1'b0;
        s_valid = 1'b1;
        obsQ.delete();
        startLoad(4097, 2);
        repeat (10) begin
            checkCount++;
            if ({err_len, pito_io_rst_n, pito_io_program, busy, s_ready} !== 5'b10000)
                $display("[TB] FAIL err_len_state: err_len/rst_n/program/busy/s_ready=%b required 10000",
                         {err_len, pito_io_rst_n, pito_io_program, busy, s_ready});
            else passCount++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        checkCount++;
        if (obsQ.size() !== 0) $display("[TB] FAIL err_len_writes: got %0d required 0", obsQ.size());
        else passCount++;
        startLoad(1, 4097);
        checkCount++;
        if (err_len !== 1'b1) $display("[TB] FAIL err_len_dmem: got %b required 1", err_len);
        else passCount++;
        doLoad(1, 1, 0, 1'b0);
    endtask

    task automatic test_reset_midload();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back($urandom);
        startLoad(5, 0);
        obsQ.delete();
        while (pito_io_program && !s_ready) @(negedge clk);
        feedWords(2, 0);
        @(negedge clk);
        checkCount++;
        if (obsQ.size() !== 2) $display("[TB] FAIL midload_writes: got %0d required 2", obsQ.size());
        else passCount++;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({pito_io_rst_n, pito_io_program, s_ready, pito_io_imem_w_en, pito_io_dmem_w_en, busy, done, err_len} !== 8'b0)
            $display("[TB] FAIL midload_reset: got %b required 00000000",
                     {pito_io_rst_n, pito_io_program, s_ready, pito_io_imem_w_en, pito_io_dmem_w_en, busy, done, err_len});
        else passCount++;
        checkCount++;
        if ({pito_io_imem_addr, pito_io_imem_data} !== 64'b0)
            $display("[TB] FAIL midload_addr: got addr=%h data=%h required 0", pito_io_imem_addr, pito_io_imem_data);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        doLoad(3, 1, 2, 1'b0);
    endtask

    task automatic test_random_loads();
        for (int n = 0; n < 4; n++) doLoad($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 2), 1'b0);
    endtask

    initial begin
        test_reset();
        doLoad(3, 2, 0, 1'b1);
        doLoad(3, 2, 1, 1'b1);
        doLoad(0, 1, 0, 1'b0);
        doLoad(0, 0, 0, 1'b0);
        test_err_len();
        test_reset_midload();
        test_random_loads();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
